axis_broadcaster_reg: RTL and testbench
=======================================

# axis_broadcaster_reg

Registered, parametrised AXI4-Stream 1-to-N broadcaster. It sits between a single stream source (e.g. the audio sample path) and NUM_OUTPUTS consumers (e.g. FFT front end, level meter, DMA). It replaces the two-output combinational broadcaster. Each beat is captured once, then presented to every enabled output. Each output can accept it in a different cycle. M_AXIS_TVALID never depends on M_AXIS_TREADY. A per-packet channel-enable mask selects which consumers receive each packet.

## Interface
Parameters:
- DATA_WIDTH, 32, TDATA width per channel (≥1)
- NUM_OUTPUTS, 2, number of master channels (1..16)

Ports:
- AXIS_ACLK  in  1  sole clock; all logic on rising edge
- AXIS_ARESET  in  1  reset, synchronous, active-high
- CH_ENABLE  in  NUM_OUTPUTS  channel enable mask, bit i = output i; sampled at packet start
- S_AXIS_TDATA  in  DATA_WIDTH  slave data
- S_AXIS_TVALID  in  1  slave valid
- S_AXIS_TLAST  in  1  slave end-of-packet
- S_AXIS_TREADY  out  1  slave ready
- M_AXIS_TDATA  out  NUM_OUTPUTS*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- M_AXIS_TVALID  out  NUM_OUTPUTS  per-channel valid
- M_AXIS_TLAST  out  NUM_OUTPUTS  per-channel last
- M_AXIS_TREADY  in  NUM_OUTPUTS  per-channel ready
- STALL_CNT  out  32  stall counter (present only with BROADCASTER_STALL_CNT_EN)

## Operation
- State: data_q, last_q, pending[NUM_OUTPUTS-1:0], mask_q[NUM_OUTPUTS-1:0], in_pkt.
- Output side: M_AXIS_TVALID[i] = pending[i]. Every channel's TDATA equals data_q and every channel's TLAST equals last_q. Channel i completes when pending[i] & M_AXIS_TREADY[i]; pending[i] then clears.
- remaining = pending & ~M_AXIS_TREADY. S_AXIS_TREADY = ~AXIS_ARESET & (remaining == 0).
  - S_AXIS_TREADY is combinational from M_AXIS_TREADY (ready-to-ready path only).
  - This gives 1 beat/cycle throughput when all enabled outputs are ready.
- Input accept (S_AXIS_TVALID & S_AXIS_TREADY):
  - data_q ← S_AXIS_TDATA, last_q ← S_AXIS_TLAST.
  - The effective mask is CH_ENABLE if in_pkt=0, else mask_q. If in_pkt=0, mask_q ← CH_ENABLE.
  - pending ← effective mask.
  - in_pkt ← ~S_AXIS_TLAST.
- Without an accept: pending ← remaining; data_q, last_q and mask_q hold.
- Packet FSM (in_pkt):
  - IDLE (0) → IN_PKT (1) on accept with TLAST=0.
  - IN_PKT → IDLE on accept with TLAST=1.
  - A single-beat packet (TLAST=1 with in_pkt=0) stays IDLE.
- Mask rules:
  - CH_ENABLE changes mid-packet have no effect until the next packet's first beat.
  - Mask all-zero: beats are accepted at full rate and dropped; pending stays 0, but the FSM still tracks TLAST.
- Disabled channels never assert TVALID, and their TREADY is ignored.

## Timing
- Latency: a beat accepted at edge k appears on M_AXIS_TVALID from cycle k+1.
- Back-to-back: the same edge may clear the last pending bit and capture the next beat, so there are no bubbles.
- Per-channel skew is unbounded. The held beat stays stable (data, last, valid) until all enabled channels complete. AXI stability holds on every channel.
- Reset (any cycle, including mid-packet or with beats pending):
  - On the next edge: pending=0, data_q=0, last_q=0, mask_q=0, in_pkt=0, STALL_CNT=0.
  - Pending beats are discarded.
  - While AXIS_ARESET=1: S_AXIS_TREADY=0 and all M_AXIS_TVALID=0.
- Simultaneous events: an output completing in the same cycle as a new accept is treated as completion of the old beat; the new pending mask is then loaded.

## Configuration
- BROADCASTER_STALL_CNT_EN defined: the STALL_CNT port exists.
  - Increments each cycle where S_AXIS_TVALID=1 and S_AXIS_TREADY=0, with AXIS_ARESET=0.
  - Saturates at 0xFFFFFFFF; cleared only by reset.
- Undefined: the STALL_CNT port and counter logic are absent. All other behaviour is identical.

## Test plan
- NUM_OUTPUTS=3, CH_ENABLE=3'b111, all TREADY=1, stream 0x1..0x8 with TLAST on 0x8 → every channel shows 0x1..0x8 one cycle later, 8 consecutive valid cycles, TLAST on the 8th beat; S_AXIS_TREADY constantly 1.
- All outputs enabled, channel 1 TREADY=0 for 5 cycles after first valid → ch0/ch2 complete in the first cycle; ch1 TVALID held 5 cycles with stable data; S_AXIS_TREADY=0 for those cycles. With the macro enabled, STALL_CNT=5.
- CH_ENABLE=3'b101 at packet start, switched to 3'b010 on beat 2 of a 4-beat packet → all 4 beats appear on ch0/ch2 only; the next packet appears on ch1 only.
- CH_ENABLE=0, 4-beat packet → S_AXIS_TREADY=1 every cycle; no M_AXIS_TVALID asserted; in_pkt returns to 0 after TLAST.
- Assert AXIS_ARESET for 1 cycle with ch1 pending mid-packet → next cycle all TVALID=0; S_AXIS_TREADY=0 during reset, 1 after. The next beat is treated as a packet start and samples the new CH_ENABLE.
- DATA_WIDTH=8, NUM_OUTPUTS=1, random TVALID/TREADY, 1000 beats → output sequence equals input sequence, with no duplicates or drops.

Source files
------------

// File: rtl/axis_broadcaster_reg.sv
// Registered AXI4-Stream 1-to-N broadcaster: one beat is held and offered to every enabled output, with one cycle of latency and independent per-output completion.
// S_AXIS_TREADY is high only when no held beat is still owed to a stalled output. Optional stall counter: BROADCASTER_STALL_CNT_EN.
module axis_broadcaster_reg #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_OUTPUTS = 2
) (
  input  logic                              AXIS_ACLK,
  input  logic                              AXIS_ARESET,
  input  logic [NUM_OUTPUTS-1:0]            CH_ENABLE,
  input  logic [DATA_WIDTH-1:0]             S_AXIS_TDATA,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [NUM_OUTPUTS-1:0]            M_AXIS_TVALID,
  output logic [NUM_OUTPUTS-1:0]            M_AXIS_TLAST,
  input  logic [NUM_OUTPUTS-1:0]            M_AXIS_TREADY
`ifdef BROADCASTER_STALL_CNT_EN
  ,
  output logic [31:0]                       STALL_CNT
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_last;
  logic [NUM_OUTPUTS-1:0]  r_pending;
  logic [NUM_OUTPUTS-1:0]  r_mask;
  logic [NUM_OUTPUTS-1:0]  w_remaining;
  logic [NUM_OUTPUTS-1:0]  w_eff_mask;
  logic                    w_s_rdy;
  logic                    w_accept;

  // Outputs completing this cycle free the holding register for the next beat.
  assign w_remaining = r_pending & ~M_AXIS_TREADY;
  assign w_s_rdy     = ~AXIS_ARESET & (w_remaining == '0);
  assign w_accept    = S_AXIS_TVALID & w_s_rdy;
  assign w_eff_mask  = (r_state == ST_IDLE) ? CH_ENABLE : r_mask;

  assign S_AXIS_TREADY = w_s_rdy;
  assign M_AXIS_TVALID = r_pending & {NUM_OUTPUTS{~AXIS_ARESET}};
  assign M_AXIS_TDATA  = {NUM_OUTPUTS{r_data}};
  assign M_AXIS_TLAST  = {NUM_OUTPUTS{r_last}};

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = S_AXIS_TLAST ? ST_IDLE : ST_IN_PKT;
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      r_data    <= '0;
      r_last    <= 1'b0;
      r_pending <= '0;
      r_mask    <= '0;
    end else if (w_accept) begin
      r_data    <= S_AXIS_TDATA;
      r_last    <= S_AXIS_TLAST;
      r_pending <= w_eff_mask;
      if (r_state == ST_IDLE) begin
        r_mask <= CH_ENABLE;
      end
    end else begin
      r_pending <= w_remaining;
    end
  end

`ifdef BROADCASTER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      r_stall_cnt <= '0;
    end else if (S_AXIS_TVALID && !w_s_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_axis_broadcaster_reg.sv
// Bench for axis_broadcaster_reg: a 3-output 32-bit instance with directed and random traffic, and a 1-output 8-bit instance with random traffic.
module tb_axis_broadcaster_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- instance A: 3 outputs x 32 bits ----------------
  logic        a_rst = 1'b1;
  logic [2:0]  a_ch_en = 3'b111;
  logic [31:0] a_s_tdata = '0;
  logic        a_s_tvalid = 1'b0;
  logic        a_s_tlast = 1'b0;
  logic        a_s_tready;
  logic [95:0] a_m_tdata;
  logic [2:0]  a_m_tvalid;
  logic [2:0]  a_m_tlast;
  logic [2:0]  a_m_tready = 3'b111;
`ifdef BROADCASTER_STALL_CNT_EN
  logic [31:0] a_stall;
  logic [31:0] b_stall;
`endif

  axis_broadcaster_reg #(.DATA_WIDTH(32), .NUM_OUTPUTS(3)) dut_a (
    .AXIS_ACLK(clk),
    .AXIS_ARESET(a_rst),
    .CH_ENABLE(a_ch_en),
    .S_AXIS_TDATA(a_s_tdata),
    .S_AXIS_TVALID(a_s_tvalid),
    .S_AXIS_TLAST(a_s_tlast),
    .S_AXIS_TREADY(a_s_tready),
    .M_AXIS_TDATA(a_m_tdata),
    .M_AXIS_TVALID(a_m_tvalid),
    .M_AXIS_TLAST(a_m_tlast),
`ifdef BROADCASTER_STALL_CNT_EN
    .STALL_CNT(a_stall),
`endif
    .M_AXIS_TREADY(a_m_tready)
  );

  // Reference: per-channel queues of owed beats, plus packet-level mask tracking.
  logic [32:0] q [3][$];
  bit          m_in_pkt = 0;
  logic [2:0]  m_pkt_mask = '0;
  int          m_stall = 0;
  int          rx [3] = '{0, 0, 0};
  int          lo_cnt = 0;
  int          tv_cnt = 0;
  bit          a_exp_rdy;
  bit          a_exp_v;
  logic [2:0]  a_msk;

  always @(negedge clk) begin
    a_exp_rdy = !a_rst;
    for (int i = 0; i < 3; i++)
      if (q[i].size() != 0 && !a_m_tready[i]) a_exp_rdy = 0;
    chk("a_s_tready", {63'd0, a_s_tready}, {63'd0, a_exp_rdy});
    for (int i = 0; i < 3; i++) begin
      a_exp_v = !a_rst && q[i].size() != 0;
      chk($sformatf("a_tvalid%0d", i), {63'd0, a_m_tvalid[i]}, {63'd0, a_exp_v});
      if (a_exp_v) begin
        chk($sformatf("a_tdata%0d", i), {32'd0, a_m_tdata[i*32 +: 32]}, {32'd0, q[i][0][31:0]});
        chk($sformatf("a_tlast%0d", i), {63'd0, a_m_tlast[i]}, {63'd0, q[i][0][32]});
      end
    end
`ifdef BROADCASTER_STALL_CNT_EN
    chk("a_stall_cnt", {32'd0, a_stall}, 64'(m_stall));
`endif
    if (a_s_tvalid && !a_s_tready) lo_cnt++;
    if (a_m_tvalid != 3'b000) tv_cnt++;
    if (a_rst) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      m_in_pkt = 0;
      m_pkt_mask = '0;
      m_stall = 0;
    end else begin
      if (a_s_tvalid && !a_exp_rdy) m_stall++;
      for (int i = 0; i < 3; i++)
        if (q[i].size() != 0 && a_m_tready[i]) begin
          void'(q[i].pop_front());
          rx[i]++;
        end
      if (a_s_tvalid && a_exp_rdy) begin
        a_msk = m_in_pkt ? m_pkt_mask : a_ch_en;
        if (!m_in_pkt) m_pkt_mask = a_ch_en;
        for (int i = 0; i < 3; i++)
          if (a_msk[i]) q[i].push_back({a_s_tlast, a_s_tdata});
        m_in_pkt = !a_s_tlast;
      end
    end
  end

  // ---------------- instance B: 1 output x 8 bits ----------------
  logic       b_rst = 1'b1;
  logic [0:0] b_ch_en = 1'b1;
  logic [7:0] b_s_tdata = '0;
  logic       b_s_tvalid = 1'b0;
  logic       b_s_tlast = 1'b0;
  logic       b_s_tready;
  logic [7:0] b_m_tdata;
  logic [0:0] b_m_tvalid;
  logic [0:0] b_m_tlast;
  logic [0:0] b_m_tready = 1'b1;

  axis_broadcaster_reg #(.DATA_WIDTH(8), .NUM_OUTPUTS(1)) dut_b (
    .AXIS_ACLK(clk),
    .AXIS_ARESET(b_rst),
    .CH_ENABLE(b_ch_en),
    .S_AXIS_TDATA(b_s_tdata),
    .S_AXIS_TVALID(b_s_tvalid),
    .S_AXIS_TLAST(b_s_tlast),
    .S_AXIS_TREADY(b_s_tready),
    .M_AXIS_TDATA(b_m_tdata),
    .M_AXIS_TVALID(b_m_tvalid),
    .M_AXIS_TLAST(b_m_tlast),
`ifdef BROADCASTER_STALL_CNT_EN
    .STALL_CNT(b_stall),
`endif
    .M_AXIS_TREADY(b_m_tready)
  );

  logic [8:0] qb [$];
  int         b_rx = 0;
  bit         b_exp_rdy;

  always @(negedge clk) begin
    b_exp_rdy = !b_rst && (qb.size() == 0 || b_m_tready[0]);
    chk("b_s_tready", {63'd0, b_s_tready}, {63'd0, b_exp_rdy});
    chk("b_tvalid", {63'd0, b_m_tvalid[0]}, {63'd0, !b_rst && qb.size() != 0});
    if (qb.size() != 0 && !b_rst) begin
      chk("b_tdata", {56'd0, b_m_tdata}, {56'd0, qb[0][7:0]});
      chk("b_tlast", {63'd0, b_m_tlast[0]}, {63'd0, qb[0][8]});
    end
    if (b_rst) qb.delete();
    else begin
      if (qb.size() != 0 && b_m_tready[0]) begin
        void'(qb.pop_front());
        b_rx++;
      end
      if (b_s_tvalid && b_exp_rdy) qb.push_back({b_s_tlast, b_s_tdata});
    end
  end

  // ---------------- stimulus helpers (callers sit at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] d, input bit l);
    a_s_tdata = d; a_s_tlast = l; a_s_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_s_tready) begin
        @(posedge clk); #1;
        a_s_tvalid = 1'b0;
        return;
      end
    end
    chk("a_send_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    a_s_tvalid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input bit l);
    b_s_tdata = d; b_s_tlast = l; b_s_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b_s_tready) begin
        @(posedge clk); #1;
        b_s_tvalid = 1'b0;
        return;
      end
    end
    chk("b_send_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    b_s_tvalid = 1'b0;
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    idle(1);
    a_rst = 1'b0;
  endtask

  int  base [3];
  int  lo0;
  int  tv0;
  bit  done_a = 0;
  bit  done_b = 0;

  task automatic snap();
    for (int i = 0; i < 3; i++) base[i] = rx[i];
    lo0 = lo_cnt;
    tv0 = tv_cnt;
  endtask

  task automatic chk_rx(input string nm, input int e0, input int e1, input int e2);
    chk({nm, "_ch0"}, 64'(rx[0] - base[0]), 64'(e0));
    chk({nm, "_ch1"}, 64'(rx[1] - base[1]), 64'(e1));
    chk({nm, "_ch2"}, 64'(rx[2] - base[2]), 64'(e2));
  endtask

  initial begin
    idle(3);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    chk("reset_tvalid", {61'd0, a_m_tvalid}, 64'd0);
    chk("reset_s_tready", {63'd0, a_s_tready}, 64'd1);
    @(posedge clk); #1;

    // Back-to-back packet of 8 beats, everything ready.
    snap();
    for (int d = 1; d <= 8; d++) send_a(32'(d), d == 8);
    idle(2);
    chk_rx("stream8", 8, 8, 8);
    chk("stream8_no_stall", 64'(lo_cnt - lo0), 64'd0);

    // Channel 1 held off for five cycles after first valid.
    reset_a();
    a_m_tready = 3'b101;
    fork
      begin
        do @(negedge clk); while (!a_m_tvalid[1]);
        repeat (5) @(posedge clk);
        #1 a_m_tready = 3'b111;
      end
    join_none
    send_a(32'h11, 1'b0);
    send_a(32'h12, 1'b1);
    idle(2);
    chk("skew_model_stall", 64'(m_stall), 64'd5);
`ifdef BROADCASTER_STALL_CNT_EN
    chk("skew_stall_cnt", {32'd0, a_stall}, 64'd5);
`endif

    // Mask change mid-packet only takes effect on the next packet.
    snap();
    a_ch_en = 3'b101;
    send_a(32'h31, 1'b0);
    a_ch_en = 3'b010;
    send_a(32'h32, 1'b0);
    send_a(32'h33, 1'b0);
    send_a(32'h34, 1'b1);
    send_a(32'h35, 1'b0);
    send_a(32'h36, 1'b1);
    idle(2);
    chk_rx("mask_switch", 4, 2, 4);

    // All-zero mask: full-rate drop, then packet tracking must be back at idle.
    snap();
    a_ch_en = 3'b000;
    for (int d = 0; d < 4; d++) send_a(32'h40 + 32'(d), d == 3);
    idle(1);
    chk("zero_mask_no_valid", 64'(tv_cnt - tv0), 64'd0);
    chk("zero_mask_no_stall", 64'(lo_cnt - lo0), 64'd0);
    a_ch_en = 3'b001;
    send_a(32'h61, 1'b1);
    idle(2);
    chk_rx("after_zero_mask", 1, 0, 0);

    // Reset with channel 1 still owed a mid-packet beat.
    a_ch_en = 3'b111;
    a_m_tready = 3'b101;
    send_a(32'h51, 1'b0);
    idle(1);
    a_rst = 1'b1;
    @(negedge clk);
    chk("in_reset_tvalid", {61'd0, a_m_tvalid}, 64'd0);
    chk("in_reset_s_tready", {63'd0, a_s_tready}, 64'd0);
    @(posedge clk); #1;
    a_rst = 1'b0;
    @(negedge clk);
    chk("post_reset_tvalid", {61'd0, a_m_tvalid}, 64'd0);
    chk("post_reset_s_tready", {63'd0, a_s_tready}, 64'd1);
    @(posedge clk); #1;
    snap();
    a_ch_en = 3'b100;
    a_m_tready = 3'b111;
    send_a(32'h52, 1'b1);
    idle(2);
    chk_rx("post_reset_pkt", 0, 0, 1);

    // Random traffic on both instances.
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          a_ch_en = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 3) == 0) idle(1);
          send_a($urandom, $urandom_range(0, 3) == 0);
        end
        done_a = 1;
      end
      while (!done_a) begin
        @(posedge clk); #1;
        a_m_tready = 3'($urandom_range(0, 7));
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
          send_b(8'($urandom), $urandom_range(0, 4) == 0);
        end
        done_b = 1;
      end
      while (!done_b) begin
        @(posedge clk); #1;
        b_m_tready[0] = ($urandom_range(0, 3) != 0);
      end
    join
    a_m_tready = 3'b111;
    b_m_tready = 1'b1;
    idle(4);
    chk("b_beats_out", 64'(b_rx), 64'd1000);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    chk("a_drained", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
